// File: rtl/sram_rr_scheduler_if.sv
// rtl/sram_rr_scheduler_if.sv - client command/response port of the SRAM scheduler
interface sram_rr_scheduler_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/sram_rr_scheduler.sv
// rtl/sram_rr_scheduler.sv - two-port round-robin access scheduler for an asynchronous SRAM
module sram_rr_scheduler #(
  parameter int AW          = 19,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_rr_scheduler_if.slave a,
  sram_rr_scheduler_if.slave b,
  output logic               busy,
  output logic [AW-1:0]      sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [DW-1:0]      sram_dat_wr,
  output logic               sram_dat_oe,
  input  logic [DW-1:0]      sram_dat_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;  // 0 = port A, 1 = port B
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic          busy_d, ce_n_d, oe_n_d, we_n_d, dat_oe_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] dat_wr_d;
  logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic          a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          win, win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // On a tie the port that did not win last time goes next.
  assign win       = (a.req && b.req) ? !last_q : !a.req;
  assign win_we    = win ? b.we    : a.we;
  assign win_addr  = win ? b.addr  : a.addr;
  assign win_wdata = win ? b.wdata : a.wdata;

  assign a.ack    = a_ack_q;
  assign b.ack    = b_ack_q;
  assign a.rvalid = a_rvalid_q;
  assign b.rvalid = b_rvalid_q;
  assign a.rdata  = a_rdata_q;
  assign b.rdata  = b_rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;
    we_d       = we_q;
    busy_d     = 1'b0;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dat_oe_d   = 1'b0;
    addr_d     = sram_addr;
    dat_wr_d   = sram_dat_wr;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (a.req || b.req) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_CYCLES - 1);
          last_d   = win;
          sel_d    = win;
          we_d     = win_we;
          busy_d   = 1'b1;
          a_ack_d  = !win;
          b_ack_d  = win;
          ce_n_d   = 1'b0;
          oe_n_d   = win_we;
          we_n_d   = !win_we;
          dat_oe_d = win_we;
          addr_d   = win_addr;
          dat_wr_d = win_wdata;
        end
      end
      ACCESS: begin
        busy_d   = 1'b1;
        dat_oe_d = we_q;
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: sample read data and release strobes for recovery.
          state_d = RECOVER;
          if (!we_q) begin
            a_rvalid_d = !sel_q;
            b_rvalid_d = sel_q;
            if (sel_q) b_rdata_d = sram_dat_rd;
            else       a_rdata_d = sram_dat_rd;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = we_q;
          we_n_d = !we_q;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      busy        <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dat_oe <= 1'b0;
      sram_addr   <= '0;
      sram_dat_wr <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      busy        <= busy_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_dat_oe <= dat_oe_d;
      sram_addr   <= addr_d;
      sram_dat_wr <= dat_wr_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end
endmodule

// File: tb/tb_sram_rr_scheduler.sv
// tb/tb_sram_rr_scheduler.sv - randomized reference-model bench for sram_rr_scheduler
`timescale 1ns/1ps
module tb_sram_rr_scheduler;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int W0 = 1;
  localparam int W1 = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index order everywhere: [dut k][port p], port 0 = A, port 1 = B.
  logic [1:0]                 rst_s;
  logic [1:0][1:0]            req_s, we_s;
  logic [1:0][1:0][AW-1:0]    addr_s;
  logic [1:0][1:0][DW-1:0]    wd_s;
  wire  [1:0][1:0]            ack_o, rv_o;
  wire  [1:0][1:0][DW-1:0]    rd_o;
  wire  [1:0]                 busy_o, ce_o, oe_o, wen_o, doe_o;
  wire  [1:0][AW-1:0]         sa_o;
  wire  [1:0][DW-1:0]         dwr_o;
  logic [1:0][DW-1:0]         drd;

  sram_rr_scheduler_if #(.AW(AW), .DW(DW)) a0 ();
  sram_rr_scheduler_if #(.AW(AW), .DW(DW)) b0 ();
  sram_rr_scheduler_if #(.AW(AW), .DW(DW)) a1 ();
  sram_rr_scheduler_if #(.AW(AW), .DW(DW)) b1 ();

  assign a0.req = req_s[0][0]; assign a0.we = we_s[0][0]; assign a0.addr = addr_s[0][0]; assign a0.wdata = wd_s[0][0];
  assign b0.req = req_s[0][1]; assign b0.we = we_s[0][1]; assign b0.addr = addr_s[0][1]; assign b0.wdata = wd_s[0][1];
  assign a1.req = req_s[1][0]; assign a1.we = we_s[1][0]; assign a1.addr = addr_s[1][0]; assign a1.wdata = wd_s[1][0];
  assign b1.req = req_s[1][1]; assign b1.we = we_s[1][1]; assign b1.addr = addr_s[1][1]; assign b1.wdata = wd_s[1][1];
  assign ack_o[0][0] = a0.ack; assign rv_o[0][0] = a0.rvalid; assign rd_o[0][0] = a0.rdata;
  assign ack_o[0][1] = b0.ack; assign rv_o[0][1] = b0.rvalid; assign rd_o[0][1] = b0.rdata;
  assign ack_o[1][0] = a1.ack; assign rv_o[1][0] = a1.rvalid; assign rd_o[1][0] = a1.rdata;
  assign ack_o[1][1] = b1.ack; assign rv_o[1][1] = b1.rvalid; assign rd_o[1][1] = b1.rdata;

  sram_rr_scheduler #(.AW(AW), .DW(DW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .a(a0), .b(b0), .busy(busy_o[0]), .sram_addr(sa_o[0]),
    .sram_ce_n(ce_o[0]), .sram_oe_n(oe_o[0]), .sram_we_n(wen_o[0]), .sram_dat_wr(dwr_o[0]),
    .sram_dat_oe(doe_o[0]), .sram_dat_rd(drd[0]));

  sram_rr_scheduler #(.AW(AW), .DW(DW), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst_s[1]), .a(a1), .b(b1), .busy(busy_o[1]), .sram_addr(sa_o[1]),
    .sram_ce_n(ce_o[1]), .sram_oe_n(oe_o[1]), .sram_we_n(wen_o[1]), .sram_dat_wr(dwr_o[1]),
    .sram_dat_oe(doe_o[1]), .sram_dat_rd(drd[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Memory contents: preload is the initial SRAM image, env_mem is what the pins wrote,
  // ref_mem is what completed writes should have left behind.
  logic [7:0] preload [int];
  logic [7:0] env_mem [int];
  logic [7:0] ref_mem [int];

  cmd_t cmds [2][2][64];
  int   head [2][2] = '{default: 0};
  int   tail [2][2] = '{default: 0};
  int   gap_c[2][2] = '{default: 0};

  // Reference model: m_n counts cycles since the grant (0 = no access in flight).
  int            m_n    [2] = '{0, 0};
  int            m_p    [2] = '{0, 0};
  int            m_last [2] = '{1, 1};
  logic          m_we   [2] = '{0, 0};
  logic [AW-1:0] m_addr [2] = '{default: '0};
  logic [DW-1:0] m_wd   [2] = '{default: '0};
  logic [DW-1:0] m_rdata[2][2] = '{default: '0};
  logic          m_fresh[2] = '{1, 1};

  function automatic int wcyc(int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic int key(int k, logic [AW-1:0] a);
    return (k << 20) | int'(a);
  endfunction

  function automatic logic [7:0] fill(logic [AW-1:0] a);
    return a[7:0] ^ a[18:11] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] env_read(int k, logic [AW-1:0] a);
    if (env_mem.exists(key(k, a))) return env_mem[key(k, a)];
    if (preload.exists(key(k, a))) return preload[key(k, a)];
    return fill(a);
  endfunction

  function automatic logic [7:0] ref_read(int k, logic [AW-1:0] a);
    if (ref_mem.exists(key(k, a))) return ref_mem[key(k, a)];
    if (preload.exists(key(k, a))) return preload[key(k, a)];
    return fill(a);
  endfunction

  function automatic int pick(int k);
    if (req_s[k][0] && req_s[k][1]) return 1 - m_last[k];
    return req_s[k][0] ? 0 : 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_s[k]) begin
        m_n[k]        <= 0;
        m_last[k]     <= 1;
        m_rdata[k][0] <= '0;
        m_rdata[k][1] <= '0;
        m_fresh[k]    <= 1'b1;
      end else if (m_n[k] == 0) begin
        if (req_s[k][0] || req_s[k][1]) begin
          m_p[k]     <= pick(k);
          m_last[k]  <= pick(k);
          m_we[k]    <= we_s[k][pick(k)];
          m_addr[k]  <= addr_s[k][pick(k)];
          m_wd[k]    <= wd_s[k][pick(k)];
          m_n[k]     <= 1;
          m_fresh[k] <= 1'b0;
        end
      end else if (m_n[k] == wcyc(k) + 1) begin
        m_n[k] <= 0;
      end else begin
        m_n[k] <= m_n[k] + 1;
        if (m_n[k] == wcyc(k) && !m_we[k]) m_rdata[k][m_p[k]] <= ref_read(k, m_addr[k]);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack_o[k][p] === 1'b1 && head[k][p] < tail[k][p]) begin
          head[k][p]++;
          if (head[k][p] < tail[k][p]) gap_c[k][p] = cmds[k][p][head[k][p]].gap;
        end
        if (head[k][p] < tail[k][p] && gap_c[k][p] == 0) begin
          req_s[k][p]  = 1'b1;
          we_s[k][p]   = cmds[k][p][head[k][p]].we;
          addr_s[k][p] = cmds[k][p][head[k][p]].addr;
          wd_s[k][p]   = cmds[k][p][head[k][p]].wdata;
        end else begin
          req_s[k][p] = 1'b0;
          if (gap_c[k][p] > 0) gap_c[k][p]--;
        end
      end
    end
  endtask

  task automatic tick();
    int    w, n;
    logic  act, rec, wr;
    string t;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      w   = wcyc(k);
      n   = m_n[k];
      act = (n >= 1 && n <= w);
      rec = (n == w + 1);
      wr  = m_we[k];
      t   = $sformatf("w%0d", w);
      check_eq({t, "_busy"},   32'(busy_o[k]), 32'(n != 0));
      check_eq({t, "_ce_n"},   32'(ce_o[k]),   32'(!act));
      check_eq({t, "_oe_n"},   32'(oe_o[k]),   32'(!(act && !wr)));
      check_eq({t, "_we_n"},   32'(wen_o[k]),  32'(!(act && wr)));
      check_eq({t, "_dat_oe"}, 32'(doe_o[k]),  32'((act || rec) && wr));
      if (act || (rec && wr)) check_eq({t, "_addr"}, 32'(sa_o[k]), 32'(m_addr[k]));
      if ((act || rec) && wr) check_eq({t, "_dat_wr"}, 32'(dwr_o[k]), 32'(m_wd[k]));
      if (m_fresh[k]) begin
        check_eq({t, "_rst_addr"},   32'(sa_o[k]),  32'(0));
        check_eq({t, "_rst_dat_wr"}, 32'(dwr_o[k]), 32'(0));
      end
      for (int p = 0; p < 2; p++) begin
        check_eq($sformatf("%s_p%0d_ack", t, p),    32'(ack_o[k][p]), 32'(n == 1 && m_p[k] == p));
        check_eq($sformatf("%s_p%0d_rvalid", t, p), 32'(rv_o[k][p]),  32'(rec && !wr && m_p[k] == p));
        check_eq($sformatf("%s_p%0d_rdata", t, p),  32'(rd_o[k][p]),  32'(m_rdata[k][p]));
      end
      if (rec && wr) ref_mem[key(k, m_addr[k])] = m_wd[k];
      if (ce_o[k] === 1'b0 && wen_o[k] === 1'b0) env_mem[key(k, sa_o[k])] = dwr_o[k];
      drd[k] = (ce_o[k] === 1'b0 && oe_o[k] === 1'b0) ? env_read(k, sa_o[k]) : 8'hEE;
    end
    drive();
  endtask

  task automatic enq(input int k, input int p, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input int gap);
    cmds[k][p][tail[k][p]] = '{we: we, addr: addr, wdata: wdata, gap: gap};
    tail[k][p]++;
  endtask

  task automatic wait_drain(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (m_n[k] != 0) done = 1'b0;
        for (int p = 0; p < 2; p++) if (head[k][p] < tail[k][p]) done = 1'b0;
      end
    end
    check_eq("drain_done", 32'(done), 32'(1));
  endtask

  initial begin
    int waited;
    rst_s  = 2'b11;
    req_s  = '0;
    we_s   = '0;
    addr_s = '0;
    wd_s   = '0;
    drd    = '0;
    preload[key(0, 19'h12345)] = 8'h5A;

    // Reset with both requests high, then single read at W=1 (A first, then B).
    enq(0, 0, 1'b0, 19'h12345, 8'h00, 0);
    enq(0, 1, 1'b0, 19'h00100, 8'h00, 0);
    drive();
    repeat (3) tick();
    rst_s = 2'b00;
    wait_drain(60);

    // W=3 write to the top address, then read it back from the other port.
    enq(1, 1, 1'b1, 19'h7FFFF, 8'hC3, 0);
    wait_drain(60);
    enq(1, 0, 1'b0, 19'h7FFFF, 8'h00, 0);
    wait_drain(60);

    // Contention at W=1: both ports held high, cross-port write/read.
    enq(0, 0, 1'b1, 19'h00200, 8'h31, 0);
    enq(0, 1, 1'b1, 19'h00201, 8'h42, 0);
    enq(0, 0, 1'b0, 19'h00201, 8'h00, 0);
    enq(0, 1, 1'b0, 19'h00200, 8'h00, 0);
    wait_drain(60);

    // Back-to-back write then read on the same port.
    enq(0, 0, 1'b1, 19'h00000, 8'h11, 0);
    enq(0, 0, 1'b0, 19'h00000, 8'h00, 0);
    wait_drain(60);

    // Reset in the second ACCESS cycle of a W=3 write.
    enq(1, 1, 1'b1, 19'h40000, 8'h99, 0);
    waited = 0;
    while (m_n[1] != 2 && waited < 30) begin
      tick();
      waited++;
    end
    check_eq("rst_mid_reached", 32'(m_n[1]), 32'(2));
    rst_s[1]   = 1'b1;
    head[1][1] = tail[1][1];
    drive();
    tick();
    rst_s[1] = 1'b0;
    repeat (6) tick();

    // Randomized traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 20; i++) begin
          enq(k, p, 1'($urandom_range(0, 1)), 19'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
      end
    end
    wait_drain(3000);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
